argmax_seq: RTL and testbench

- Sequences the shared registered greater-than comparator `cmp_gt` (1-cycle latency, strict a>b) to find the winning neuron among N class scores streamed from the output layer.
- Sits after the skin-classifier output layer. Returns the index and value of the largest score to the decision logic.
- Ties resolve to the lowest index, because the compare is strict.

---
 rtl/argmax_seq_pkg.sv | 23 ++
 rtl/argmax_seq_cmp_gt.sv | 21 ++
 rtl/argmax_seq.sv | 126 ++++++++++++
 tb/tb_argmax_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_seq_pkg.sv
// Shared definitions for the argmax sequencer: FSM state encoding and an
// elaboration-time helper for checking the index width against the score count.
package argmax_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CMP   = 3'd2;
    localparam logic [2:0] ST_UPD   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/argmax_seq_cmp_gt.sv
// Shared registered comparator: gt is (a > b), unsigned and strict, one cycle
// after the operands are presented.
module cmp_gt #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt <= 1'b0;
        end else begin
            gt <= (a > b);
        end
    end

endmodule

// File: rtl/argmax_seq.sv
// Streams N class scores through one shared comparator and reports the index
// and value of the largest; ties keep the lowest index.
module argmax_seq
    import argmax_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val
);

    generate
        if (N < 1 || N > 256 || IDX_W < clog2(N) || IDX_W < 1) begin : g_bad_params
            $error("argmax_seq: N must be 1..256 and 2**IDX_W >= N");
        end
    endgenerate

    localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(N - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W:0]    cnt_q;
    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [DATA_W-1:0] cand_val_q;
    logic [IDX_W-1:0]  cand_idx_q;
    logic              gt_p1;
    logic              accept;
    logic              upd;

    // Stage boundary: candidate vs best, result registered for the UPD state
    cmp_gt #(.DATA_W(DATA_W)) u_cmp_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (cand_val_q),
        .b     (best_val_q),
        .gt    (gt_p1)
    );

    assign accept   = (state_q == ST_FETCH) && in_valid && !abort;
    assign upd      = (state_q == ST_UPD) && !abort;
    assign in_ready = (state_q == ST_FETCH);
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_CMP) || (state_q == ST_UPD);
    assign done     = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !abort) state_d = ST_FETCH;
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    if (cnt_q == '0) state_d = (N == 1) ? ST_DONE : ST_FETCH;
                    else             state_d = ST_CMP;
                end
            end
            ST_CMP:   state_d = abort ? ST_IDLE : ST_UPD;
            ST_UPD: begin
                if (abort)                  state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                        state_d = ST_FETCH;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The result registers load the post-update best so a final win in UPD is visible with done
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (accept && cnt_q == '0) begin
            best_val_d = in_data;
            best_idx_d = '0;
        end else if (upd && gt_p1) begin
            best_val_d = cand_val_q;
            best_idx_d = cand_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            cand_val_q <= '0;
            cand_idx_q <= '0;
            max_val    <= '0;
            max_idx    <= '0;
        end else begin
            state_q    <= state_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            if (state_q == ST_IDLE && start && !abort) begin
                cnt_q <= '0;
            end else if (accept) begin
                if (cnt_q == '0) begin
                    if (N != 1) cnt_q <= CNT_ONE;
                end else begin
                    cand_val_q <= in_data;
                    cand_idx_q <= cnt_q[IDX_W-1:0];
                end
            end else if (upd && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state_d == ST_DONE) begin
                max_val <= best_val_d;
                max_idx <= best_idx_d;
            end
        end
    end

endmodule

// File: tb/tb_argmax_seq.sv
// Scoreboard bench for argmax_seq: directed score vectors with hand-computed
// winners, an N=8 and an N=1 instance, abort and mid-decision reset.
module tb_argmax_seq;

    typedef struct {
        int idx;
        int val;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [15:0] in_data;
    logic        in_ready, busy, done;
    logic [2:0]  max_idx;
    logic [15:0] max_val;

    logic        s1_start, s1_abort, s1_in_valid;
    logic [15:0] s1_in_data;
    logic        s1_in_ready, s1_busy, s1_done;
    logic [2:0]  s1_max_idx;
    logic [15:0] s1_max_val;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc8 = 0;
    int   start_cyc1 = 0;
    int   ready_viol = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    argmax_seq #(.DATA_W(16), .N(8), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .max_idx(max_idx), .max_val(max_val)
    );

    argmax_seq #(.DATA_W(16), .N(1), .IDX_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort),
        .in_valid(s1_in_valid), .in_data(s1_in_data), .in_ready(s1_in_ready),
        .busy(s1_busy), .done(s1_done), .max_idx(s1_max_idx), .max_val(s1_max_val)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push8(input int i, input int v, input int l);
        exp_t e;
        e.idx = i; e.val = v; e.lat = l;
        q8.push_back(e);
    endtask

    // Monitors: pop an expectation whenever done is presented
    always @(negedge clk) begin
        if (in_ready && !busy) ready_viol++;
        if (rst_n && done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done_n8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("max_idx_n8", int'(max_idx), e8.idx);
                chk("max_val_n8", int'(max_val), e8.val);
                if (e8.lat >= 0) chk("latency_n8", cyc - start_cyc8, e8.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s1_done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done_n1", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("max_idx_n1", int'(s1_max_idx), e1.idx);
                chk("max_val_n1", int'(s1_max_val), e1.val);
                if (e1.lat >= 0) chk("latency_n1", cyc - start_cyc1, e1.lat);
            end
        end
    end

    task automatic feed8(input logic [15:0] s [8], input bit gap, input int abort_at,
                         input bit extra_start);
        int  k;
        int  n;
        bit  hs;
        bit  ab;
        k = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        in_data    = s[0];
        in_valid   = !gap;
        start_cyc8 = cyc;
        for (int t = 0; t < 400 && k < 8; t++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            ab = abort;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            n = cyc - start_cyc8;
            if (hs && !ab) k++;
            if (ab) break;
            if (k < 8) in_data = s[k];
            in_valid = gap ? ((cyc % 4) == 0) : (k < 8);
            if (extra_start && (n == 5 || n == 12)) start = 1'b1;
            if (abort_at == n) abort = 1'b1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort_at < 0 && k < 8) chk("feed_timeout", k, 8);
    endtask

    task automatic drain();
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            if (q8.size() == 0 && q1.size() == 0) break;
        end
        if (q8.size() != 0 || q1.size() != 0) begin
            chk("done_timeout", q8.size() + q1.size(), 0);
            q8.delete();
            q1.delete();
        end
        @(posedge clk); #1;
    endtask

    logic [15:0] sv [8];

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        s1_start = 1'b0; s1_abort = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_max_idx", int'(max_idx), 0);
        chk("rst_max_val", int'(max_val), 0);
        chk("rst_busy_n1", int'(s1_busy), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sv = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd7, 16'd1, 16'd0, 16'd5};
        push8(1, 9, 23);
        feed8(sv, 1'b0, -1, 1'b0);
        drain();

        sv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd65535};
        push8(7, 65535, 23);
        feed8(sv, 1'b0, -1, 1'b0);
        drain();

        sv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        push8(0, 0, 23);
        feed8(sv, 1'b0, -1, 1'b0);
        drain();

        begin
            exp_t e;
            e.idx = 0; e.val = 42; e.lat = 2;
            q1.push_back(e);
        end
        @(posedge clk); #1;
        s1_start = 1'b1; s1_in_data = 16'd42; s1_in_valid = 1'b1; start_cyc1 = cyc;
        @(posedge clk); #1;
        s1_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 s1_in_valid = 1'b0;
        drain();

        sv = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd7, 16'd1, 16'd0, 16'd5};
        push8(1, 9, -1);
        feed8(sv, 1'b1, -1, 1'b1);
        drain();

        sv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        feed8(sv, 1'b0, 10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_held_idx", int'(max_idx), 1);
        chk("abort_held_val", int'(max_val), 9);

        push8(7, 8, 23);
        feed8(sv, 1'b0, -1, 1'b0);
        drain();

        @(posedge clk); #1;
        start = 1'b1; in_data = 16'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_data = 16'd6;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_max_idx", int'(max_idx), 0);
        chk("midrst_max_val", int'(max_val), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sv = '{16'd4, 16'd4, 16'd6, 16'd2, 16'd6, 16'd1, 16'd3, 16'd0};
        push8(2, 6, 23);
        feed8(sv, 1'b0, -1, 1'b0);
        drain();

        repeat (5) @(posedge clk);
        chk("in_ready_only_while_busy", ready_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
